chart_info_loader: RTL

//  Responder side of the chart-select interface used by the menu page.

---
 rtl/chart_info_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/chart_info_loader.sv
// Chart header fetcher: follows req_id, reads NAME_LEN name bytes plus a 16-bit
// note count from the chart ROM and presents them with info_valid.
//
// state | meaning
// IDLE  | header for loaded_id presented (or empty header pending one edge)
// FETCH | issuing header reads; capturing the byte of the previous read
// DRAIN | capturing the last note_cnt byte, saturating, raising info_valid
module chart_info_loader #(
  parameter int NAME_LEN   = 12,
  parameter int MAX_CHARTS = 6,
  parameter int HDR_STRIDE = 16,
  parameter int ADDR_W     = 10,
  parameter int MAX_NOTES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req_id,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [7:0]            rom_data,
  output logic [8*NAME_LEN-1:0] info_name,
  output logic [15:0]           info_note_cnt,
  output logic                  info_valid,
  output logic [7:0]            loaded_id,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NAME_LEN + 2);
  localparam logic [IDX_W-1:0] CNT_LO_IDX = IDX_W'(NAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NAME_LEN + 1);
  localparam logic [8*NAME_LEN-1:0] SPACES = {NAME_LEN{8'h20}};
  localparam logic [15:0] SAT_CNT = 16'(MAX_NOTES);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              empty_pend;

  logic              req_change;
  logic              req_empty;
  logic [ADDR_W-1:0] new_base;
  logic [IDX_W-1:0]  cap_idx;
  logic [15:0]       cnt_full;

  assign req_change = (req_id != loaded_id);
  assign req_empty  = (req_id == 8'd0) || (req_id > 8'(MAX_CHARTS));
  assign new_base   = ADDR_W'((32'(req_id) - 32'd1) * 32'(HDR_STRIDE));
  // rom_data always belongs to the read issued one cycle before the current one
  assign cap_idx    = idx - IDX_W'(1);
  assign cnt_full   = {rom_data, info_note_cnt[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      empty_pend    <= 1'b0;
      rom_en        <= 1'b0;
      rom_addr      <= '0;
      info_name     <= SPACES;
      info_note_cnt <= 16'd0;
      info_valid    <= 1'b0;
      loaded_id     <= 8'hFF;
      busy          <= 1'b0;
    end else if (req_change) begin
      // New request, also aborts any fetch in flight; its pending capture is dropped
      loaded_id  <= req_id;
      info_valid <= 1'b0;
      if (req_empty) begin
        info_name     <= SPACES;
        info_note_cnt <= 16'd0;
        empty_pend    <= 1'b1;
        rom_en        <= 1'b0;
        busy          <= 1'b0;
        state         <= IDLE;
      end else begin
        empty_pend <= 1'b0;
        idx        <= '0;
        rom_addr   <= new_base;
        rom_en     <= 1'b1;
        busy       <= 1'b1;
        state      <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          if (empty_pend) begin
            info_valid <= 1'b1;
            empty_pend <= 1'b0;
          end
        end
        FETCH: begin
          if (idx != '0) begin
            for (int i = 0; i < NAME_LEN; i++) begin
              if (cap_idx == IDX_W'(i)) info_name[8*(NAME_LEN-1-i) +: 8] <= rom_data;
            end
            if (cap_idx == CNT_LO_IDX) info_note_cnt[7:0] <= rom_data;
          end
          if (idx == LAST_IDX) begin
            rom_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            idx      <= idx + IDX_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          info_note_cnt <= (cnt_full > SAT_CNT) ? SAT_CNT : cnt_full;
          info_valid    <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
